// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/response bundle.
// master = fetch side (req, addr out); slave = memory side (rdata, ready out).
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, variable-latency imem fetch, one-entry skid, IF/ID reg.
// Ports: clk, rst_n, stall, redirect, redirect_pc, imem (master), if_id_*, halted.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          redirect,
  input  logic [15:0]   redirect_pc,
  fetch_stage_if.master imem,
  output logic [15:0]   if_id_instr,
  output logic [15:0]   if_id_pc2,
  output logic          if_id_valid,
  output logic          halted
);

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HALT
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] pcNext;
  logic [15:0] reqAddr;
  logic [15:0] skidInstr;
  logic [15:0] skidPc2;
  logic        skidValid;
  logic        squash;
  logic        req;
  logic        accept;
  logic        keep;
  logic        drain;
  logic        wordHalt;
  logic        skidHalt;

  assign pcNext = pc + 16'd2;

  // A redirect cycle never opens a new request, so the
  // address seen by memory can't change under a live req.
  assign req = rst_n &&
    ((state == WAIT) ||
     (state == FETCH && !stall && !skidValid && !redirect));

  assign imem.imem_req  = req;
  assign imem.imem_addr = (state == WAIT) ? reqAddr : pc;

  assign accept   = req && imem.imem_ready;
  assign keep     = accept && !squash && !redirect;
  assign drain    = (state == FETCH) && !stall && skidValid;
  assign wordHalt = imem.imem_rdata[15:11] == 5'b00000;
  assign skidHalt = skidInstr[15:11] == 5'b00000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      reqAddr     <= RESET_PC;
      skidInstr   <= NOP_INSTR;
      skidPc2     <= '0;
      skidValid   <= 1'b0;
      squash      <= 1'b0;
      if_id_instr <= NOP_INSTR;
      if_id_pc2   <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (redirect) begin
      pc          <= redirect_pc & 16'hFFFE;
      if_id_instr <= NOP_INSTR;
      if_id_pc2   <= '0;
      if_id_valid <= 1'b0;
      skidValid   <= 1'b0;
      halted      <= 1'b0;
      // Outstanding response still owed: stay and eat it.
      if (state == WAIT && !imem.imem_ready) begin
        squash <= 1'b1;
      end else begin
        squash <= 1'b0;
        state  <= FETCH;
      end
    end else if (state != HALT) begin
      if (drain) begin
        if_id_instr <= skidInstr;
        if_id_pc2   <= skidPc2;
        if_id_valid <= 1'b1;
        skidValid   <= 1'b0;
        if (skidHalt) begin
          halted <= 1'b1;
          state  <= HALT;
        end
      end else if (keep) begin
        pc    <= pcNext;
        state <= FETCH;
        if (stall) begin
          skidInstr <= imem.imem_rdata;
          skidPc2   <= pcNext;
          skidValid <= 1'b1;
        end else begin
          if_id_instr <= imem.imem_rdata;
          if_id_pc2   <= pcNext;
          if_id_valid <= 1'b1;
          if (wordHalt) begin
            halted <= 1'b1;
            state  <= HALT;
          end
        end
      end else begin
        if (!stall) begin
          if_id_instr <= NOP_INSTR;
          if_id_pc2   <= '0;
          if_id_valid <= 1'b0;
        end
        if (accept) begin
          squash <= 1'b0;
          state  <= FETCH;
        end else if (req && state == FETCH) begin
          reqAddr <= pc;
          state   <= WAIT;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized + directed bench for fetch_stage
// against a transaction-level model of the fetch rules.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc2;
  logic        if_id_valid;
  logic        halted;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus),
    .if_id_instr (if_id_instr),
    .if_id_pc2   (if_id_pc2),
    .if_id_valid (if_id_valid),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  logic [15:0] mem [0:65535];
  int memWait = -1;
  int fixLat  = 0;
  int maxLat  = 3;

  // model state
  logic [15:0] mPc, mPendAddr, mInstr, mPc2;
  bit          mPend, mSquash, mValid, mHalted;
  logic [31:0] skidQ [$];

  // sampled DUT values of the last cycle
  logic        sReq, sValid, sHalted;
  logic [15:0] sAddr, sInstr, sPc2;
  int          cyc = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic modelReset();
    mPc = 16'h0000; mPendAddr = 16'h0000;
    mInstr = 16'h0800; mPc2 = 16'h0000;
    mPend = 0; mSquash = 0; mValid = 0; mHalted = 0;
    skidQ.delete();
  endtask

  task automatic bubble();
    mInstr = 16'h0800; mPc2 = 16'h0000; mValid = 0;
  endtask

  task automatic present(logic [15:0] i, logic [15:0] p);
    mInstr = i; mPc2 = p; mValid = 1;
    if (i[15:11] == 5'd0) mHalted = 1;
  endtask

  function automatic bit expReq(bit st, bit rd);
    return mPend || (!mHalted && !st && skidQ.size() == 0 && !rd);
  endfunction

  task automatic modelStep(bit st, bit rd, logic [15:0] rp,
                           bit req, bit rdy, logic [15:0] word);
    bit got;
    logic [31:0] e;
    got = req && rdy;
    if (rd) begin
      mPc = rp & 16'hFFFE;
      bubble();
      skidQ.delete();
      mHalted = 0;
      mSquash = mPend && !got;
      mPend   = mSquash;
    end else if (mHalted) begin
    end else if (!st && skidQ.size() != 0) begin
      e = skidQ.pop_front();
      present(e[31:16], e[15:0]);
    end else if (got && !mSquash) begin
      mPc = mPc + 16'd2;
      mPend = 0;
      if (st) skidQ.push_back({word, mPc});
      else present(word, mPc);
    end else begin
      if (!st) bubble();
      if (got) begin
        mPend = 0; mSquash = 0;
      end else if (req && !mPend) begin
        mPend = 1; mPendAddr = mPc;
      end
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic cycle(bit st, bit rd, logic [15:0] rp);
    bit eReq, rdy;
    logic [15:0] eAddr, word;
    logic [50:0] act, exp;
    stall = st; redirect = rd; redirect_pc = rp;
    eReq  = expReq(st, rd);
    eAddr = mPend ? mPendAddr : mPc;
    rdy = 0;
    if (eReq) begin
      if (memWait < 0)
        memWait = (fixLat >= 0) ? fixLat : int'($urandom_range(0, maxLat));
      rdy = (memWait == 0);
    end
    word = rdy ? mem[eAddr] : 16'($urandom);
    bus.imem_ready = rdy;
    bus.imem_rdata = word;
    #1;
    sReq = bus.imem_req; sAddr = bus.imem_addr;
    sInstr = if_id_instr; sPc2 = if_id_pc2;
    sValid = if_id_valid; sHalted = halted;
    act = {sReq, sAddr, sInstr, mValid ? sPc2 : 16'h0, sValid, sHalted};
    exp = {eReq, eAddr, mValid ? mInstr : 16'h0800,
           mValid ? mPc2 : 16'h0, mValid, mHalted};
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL cycle %0d: dut req=%b addr=%h instr=%h pc2=%h v=%b h=%b model req=%b addr=%h instr=%h pc2=%h v=%b h=%b",
               cyc, sReq, sAddr, sInstr, sPc2, sValid, sHalted,
               exp[50], exp[49:34], exp[33:18], exp[17:2], exp[1], exp[0]);
    end
    @(posedge clk);
    modelStep(st, rd, rp, eReq, rdy, word);
    if (rdy) memWait = -1;
    else if (eReq) memWait--;
    cyc++;
    @(negedge clk);
  endtask

  task automatic chkReset(string nm);
    chk({nm, " req"},   bus.imem_req, 0);
    chk({nm, " addr"},  bus.imem_addr, 16'h0000);
    chk({nm, " instr"}, if_id_instr, 16'h0800);
    chk({nm, " pc2"},   if_id_pc2, 16'h0000);
    chk({nm, " valid"}, if_id_valid, 0);
    chk({nm, " halted"}, halted, 0);
  endtask

  initial begin
    int cnt;
    bit found;
    logic [15:0] last, expPc2;

    for (int a = 0; a < 65536; a++)
      mem[a] = {5'($urandom_range(1, 31)), 11'($urandom)};

    rst_n = 0; stall = 0; redirect = 0; redirect_pc = 0;
    bus.imem_ready = 0; bus.imem_rdata = 0;
    modelReset();

    repeat (2) @(negedge clk);
    #1;
    chkReset("reset");
    rst_n = 1;

    // zero-wait stream from reset
    fixLat = 0;
    for (int k = 1; k <= 5; k++) begin
      cycle(0, 0, 0);
      chk($sformatf("p1 addr%0d", k), sAddr, 16'(2 * (k - 1)));
      chk($sformatf("p1 valid%0d", k), sValid, k >= 2);
      if (k >= 2) chk($sformatf("p1 pc2 %0d", k), sPc2, 16'(2 * (k - 1)));
    end

    // 3-cycle memory: one word per 3 cycles, in order
    fixLat = 2;
    last = 16'h0008;
    cnt = 0;
    for (int j = 0; j < 12; j++) begin
      cycle(0, 0, 0);
      if (sValid) begin
        chk("p2 order", sPc2, last + 16'd2);
        last = sPc2;
        cnt++;
      end
    end
    chk("p2 words", cnt, 4);

    // stall while the response lands
    found = 0;
    for (int j = 0; j < 20 && !found; j++) begin
      if (mPend && memWait == 0) found = 1;
      else cycle(0, 0, 0);
    end
    chk("p3 setup", found, 1);
    expPc2 = mPendAddr + 16'd2;
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("p3 drained", {sValid, sPc2}, {1'b1, expPc2});
    cycle(0, 0, 0);
    chk("p3 once", sValid && sPc2 == expPc2, 0);

    // redirect while waiting on memory
    found = 0;
    for (int j = 0; j < 20 && !found; j++) begin
      if (mPend && memWait >= 1) found = 1;
      else cycle(0, 0, 0);
    end
    chk("p4 setup", found, 1);
    cycle(0, 1, 16'h0100);
    cycle(0, 0, 0);
    chk("p4 bubble", sValid, 0);
    found = 0;
    for (int j = 0; j < 20 && !found; j++) begin
      cycle(0, 0, 0);
      if (sValid) begin
        found = 1;
        chk("p4 pc2", sPc2, 16'h0102);
      end
    end
    chk("p4 resumed", found, 1);

    // HALT at 0x0010
    fixLat = 0;
    mem[16'h0010] = 16'h0000;
    cycle(0, 1, 16'h0010);
    found = 0;
    for (int j = 0; j < 10 && !found; j++) begin
      cycle(0, 0, 0);
      found = sHalted;
    end
    chk("p5 halted", found, 1);
    chk("p5 instr", {sValid, sInstr, sPc2}, {1'b1, 16'h0000, 16'h0012});
    for (int j = 0; j < 3; j++) begin
      cycle(0, 0, 0);
      chk("p5 no req", sReq, 0);
    end
    cycle(0, 1, 16'h0021);
    cycle(0, 0, 0);
    chk("p5 resume", {sReq, sAddr, sHalted}, {1'b1, 16'h0020, 1'b0});

    // PC wrap
    cycle(0, 1, 16'hFFFC);
    cycle(0, 0, 0);
    chk("p6 FFFC", sAddr, 16'hFFFC);
    cycle(0, 0, 0);
    chk("p6 FFFE", sAddr, 16'hFFFE);
    cycle(0, 0, 0);
    chk("p6 wrap", sAddr, 16'h0000);

    // async reset in the middle of a wait
    fixLat = 3;
    found = 0;
    for (int j = 0; j < 10 && !found; j++) begin
      cycle(0, 0, 0);
      found = mPend;
    end
    chk("p6 wait", found, 1);
    rst_n = 0;
    #1;
    chkReset("midreset");
    bus.imem_ready = 0;
    memWait = -1;
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;

    // random traffic with scattered HALTs
    for (int j = 0; j < 200; j++)
      mem[16'($urandom) & 16'hFFFE] = {5'd0, 11'($urandom)};
    fixLat = -1;
    maxLat = 3;
    for (int j = 0; j < 3000; j++)
      cycle($urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0,
            16'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
